// File: rtl/fibonacci_multirate.sv
// Fibonacci generator emitting LANES consecutive terms per beat over valid/ready,
// with runtime seeds, wrap/saturate arithmetic, a sticky overflow flag and a term counter.
module fibonacci_multirate #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LANES    = 2,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [WIDTH-1:0]         seed_a,
    input  logic [WIDTH-1:0]         seed_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   num,
    output logic                     overflow,
    output logic [15:0]              count
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    // Terms 0..LANES-1 form the beat; terms LANES and LANES+1 are the next pair.
    localparam int unsigned NT = LANES + 2;

    if (LANES < 1 || LANES > 4) begin : g_lanes_check
        $error("fibonacci_multirate: LANES must be in 1..4");
    end

    logic                  state;
    logic [WIDTH-1:0]      pair_a;
    logic [WIDTH-1:0]      pair_b;
    logic [NT*WIDTH-1:0]   terms;
    logic                  terms_carry;
    logic                  xfer;
    logic [16:0]           count_sum;
    logic [15:0]           count_inc;

    always_comb begin
        logic [WIDTH:0] sum;
        terms       = '0;
        terms_carry = 1'b0;
        sum         = '0;
        terms[0 +: WIDTH]     = pair_a;
        terms[WIDTH +: WIDTH] = pair_b;
        for (int unsigned k = 2; k < NT; k++) begin
            sum = {1'b0, terms[(k-1)*WIDTH +: WIDTH]} + {1'b0, terms[(k-2)*WIDTH +: WIDTH]};
            terms_carry = terms_carry | sum[WIDTH];
            // A clamped term feeds later sums, so saturation persists down the chain.
            terms[k*WIDTH +: WIDTH] = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        end
    end

    assign num       = terms[LANES*WIDTH-1:0];
    assign out_valid = (state == STATE_RUN);
    assign xfer      = out_valid & out_ready;
    assign count_sum = {1'b0, count} + 17'(LANES);
    assign count_inc = count_sum[16] ? '1 : count_sum[15:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= STATE_IDLE;
            pair_a   <= '0;
            pair_b   <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (start) begin
            state    <= STATE_RUN;
            pair_a   <= seed_a;
            pair_b   <= seed_b;
            overflow <= 1'b0;
            count    <= '0;
        end else if (state == STATE_RUN) begin
            if (xfer) begin
                count <= count_inc;
            end
            // On stop the pair is held so num keeps showing the last beat.
            if (stop) begin
                state <= STATE_IDLE;
            end else if (xfer) begin
                pair_a <= terms[LANES*WIDTH +: WIDTH];
                pair_b <= terms[(LANES+1)*WIDTH +: WIDTH];
                if (terms_carry) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
